// File: rtl/aes_pkg.sv
// Shared widths, round count and sequencer state encoding for the AES-128 round sequencer.
package aes_pkg;
    localparam int AES_BLK_W = 128;
    localparam int AES128_NR = 10;

    typedef enum logic [2:0] {
        IDLE,
        LOADKEY,
        FETCH,
        RUN,
        DONE
    } seq_state_t;
endpackage

// File: rtl/aes_wdog_timer.sv
// Stall watchdog: counts enabled cycles since the last clear, flags expiry at LIMIT.
module aes_wdog_timer #(
    parameter int LIMIT = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);
    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign expire_o = en_i && (cnt_q == W'(LIMIT));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i && !expire_o)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/aes128_round_sequencer.sv
// Drives one AES-128 encryption across the external key schedule and round unit:
// rk0 is folded in locally, rounds 1..NR are issued one at a time.
module aes128_round_sequencer
    import aes_pkg::*;
#(
    parameter int NR       = AES128_NR,
    parameter int WDOG_CYC = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [AES_BLK_W-1:0] in_data_i,
    input  logic [AES_BLK_W-1:0] in_key_i,
    output logic                 ks_load_o,
    output logic [AES_BLK_W-1:0] ks_key_o,
    output logic                 rk_req_o,
    output logic [3:0]           rk_idx_o,
    input  logic                 rk_valid_i,
    input  logic [AES_BLK_W-1:0] rk_data_i,
    output logic                 rnd_start_o,
    output logic                 rnd_last_o,
    output logic [AES_BLK_W-1:0] rnd_state_o,
    output logic [AES_BLK_W-1:0] rnd_key_o,
    input  logic                 rnd_done_i,
    input  logic [AES_BLK_W-1:0] rnd_result_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [AES_BLK_W-1:0] out_data_o,
    input  logic                 abort_i,
    output logic                 err_o
);
    seq_state_t           st_q, st_d;
    logic [AES_BLK_W-1:0] blk_q, blk_d;
    logic [AES_BLK_W-1:0] key_q, key_d;
    logic [AES_BLK_W-1:0] rk_q, rk_d;
    logic [3:0]           rnd_q, rnd_d;
    logic                 gap_q, gap_d;
    logic                 first_q, first_d;
    logic                 wd_clr, wd_en, wd_exp;

    aes_wdog_timer #(.LIMIT(WDOG_CYC)) u_wdog (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (wd_clr),
        .en_i     (wd_en),
        .expire_o (wd_exp)
    );

    always_comb begin
        st_d    = st_q;
        blk_d   = blk_q;
        key_d   = key_q;
        rk_d    = rk_q;
        rnd_d   = rnd_q;
        gap_d   = 1'b0;
        first_d = 1'b0;
        wd_clr  = 1'b1;
        wd_en   = 1'b0;
        case (st_q)
            IDLE: begin
                if (in_valid_i) begin
                    blk_d = in_data_i;
                    key_d = in_key_i;
                    rnd_d = '0;
                    st_d  = LOADKEY;
                end
            end
            LOADKEY: st_d = FETCH;
            FETCH: begin
                wd_en  = 1'b1;
                wd_clr = 1'b0;
                // gap_q marks the dead cycle between rk0 and rk1 requests
                if (rk_valid_i && !gap_q) begin
                    wd_clr = 1'b1;
                    if (rnd_q == 4'd0) begin
                        blk_d = blk_q ^ rk_data_i;
                        rnd_d = 4'd1;
                        gap_d = 1'b1;
                    end else begin
                        rk_d    = rk_data_i;
                        first_d = 1'b1;
                        st_d    = RUN;
                    end
                end
            end
            RUN: begin
                wd_en  = 1'b1;
                wd_clr = 1'b0;
                if (rnd_done_i) begin
                    wd_clr = 1'b1;
                    blk_d  = rnd_result_i;
                    if (rnd_q == 4'(NR)) begin
                        st_d = DONE;
                    end else begin
                        rnd_d = rnd_q + 4'd1;
                        st_d  = FETCH;
                    end
                end
            end
            DONE: if (out_ready_i) st_d = IDLE;
            default: st_d = IDLE;
        endcase
        if (wd_exp || (abort_i && st_q != IDLE)) begin
            st_d    = IDLE;
            blk_d   = '0;
            rk_d    = rk_q;
            rnd_d   = '0;
            gap_d   = 1'b0;
            first_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            st_q    <= IDLE;
            blk_q   <= '0;
            key_q   <= '0;
            rk_q    <= '0;
            rnd_q   <= '0;
            gap_q   <= 1'b0;
            first_q <= 1'b0;
        end else begin
            st_q    <= st_d;
            blk_q   <= blk_d;
            key_q   <= key_d;
            rk_q    <= rk_d;
            rnd_q   <= rnd_d;
            gap_q   <= gap_d;
            first_q <= first_d;
        end
    end

    assign in_ready_o  = (st_q == IDLE);
    assign ks_load_o   = (st_q == LOADKEY);
    assign ks_key_o    = key_q;
    assign rk_req_o    = (st_q == FETCH) && !gap_q;
    assign rk_idx_o    = rnd_q;
    assign rnd_start_o = (st_q == RUN) && first_q;
    assign rnd_last_o  = (st_q == RUN) && (rnd_q == 4'(NR));
    assign rnd_state_o = blk_q;
    assign rnd_key_o   = rk_q;
    assign out_valid_o = (st_q == DONE);
    assign out_data_o  = (st_q == DONE) ? blk_q : '0;
    assign err_o       = wd_exp;
endmodule

// File: tb/tb_aes128_round_sequencer.sv
// Bench: FIPS-197 key-schedule and round-unit peers with random latency, end-to-end AES model.
module tb_aes128_round_sequencer;
    logic         clk_i = 1'b0;
    logic         rst_i, in_valid_i, rk_valid_i, rnd_done_i, out_ready_i, abort_i;
    logic [127:0] in_data_i, in_key_i, rk_data_i, rnd_result_i;
    logic         in_ready_o, ks_load_o, rk_req_o, rnd_start_o, rnd_last_o, out_valid_o, err_o;
    logic [127:0] ks_key_o, rnd_state_o, rnd_key_o, out_data_o;
    logic [3:0]   rk_idx_o;

    aes128_round_sequencer dut (
        .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_data_i(in_data_i), .in_key_i(in_key_i), .ks_load_o(ks_load_o), .ks_key_o(ks_key_o),
        .rk_req_o(rk_req_o), .rk_idx_o(rk_idx_o), .rk_valid_i(rk_valid_i), .rk_data_i(rk_data_i),
        .rnd_start_o(rnd_start_o), .rnd_last_o(rnd_last_o), .rnd_state_o(rnd_state_o),
        .rnd_key_o(rnd_key_o), .rnd_done_i(rnd_done_i), .rnd_result_i(rnd_result_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
        .abort_i(abort_i), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_tests = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- FIPS-197 reference ----------------
    logic [7:0] sbox [256];

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00, x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rl(input logic [7:0] v, input int k);
        return (v << k) | (v >> (8 - k));
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    function automatic logic [127:0] aes_rk(input logic [127:0] key, input int r);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = subw({t[23:0], t[31:24]});
                t[31:24] = t[31:24] ^ rc;
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] st, input logic [127:0] k, input bit last);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] o;
        for (int b = 0; b < 16; b++) s[b] = sbox[st[127-8*b -: 8]];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) t[r+4*c] = s[r+4*((c+r)%4)];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                t[4*c]   = gm(a0, 8'd2) ^ gm(a1, 8'd3) ^ a2 ^ a3;
                t[4*c+1] = a0 ^ gm(a1, 8'd2) ^ gm(a2, 8'd3) ^ a3;
                t[4*c+2] = a0 ^ a1 ^ gm(a2, 8'd2) ^ gm(a3, 8'd3);
                t[4*c+3] = gm(a0, 8'd3) ^ a1 ^ a2 ^ gm(a3, 8'd2);
            end
        end
        for (int b = 0; b < 16; b++) o[127-8*b -: 8] = t[b];
        return o ^ k;
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
        logic [127:0] s = pt ^ aes_rk(key, 0);
        for (int r = 1; r <= 10; r++) s = aes_round(s, aes_rk(key, r), r == 10);
        return s;
    endfunction

    // ---------------- peers ----------------
    bit           zero_mode = 1'b1, hang = 1'b0;
    int           abort_round = 0;
    int           kdly = 0, rdly = 0, nstart = 0, exp_idx = 0;
    bit           busy = 1'b0;
    logic [127:0] kkey = '0, cur_key = '0, first_st = '0, cap_st = '0, cap_k = '0;

    function automatic int pick();
        return zero_mode ? 0 : int'($urandom_range(0, 20));
    endfunction

    initial begin
        rk_valid_i = 1'b0; rk_data_i = '0; rnd_done_i = 1'b0; rnd_result_i = '0; abort_i = 1'b0;
        forever begin
            @(posedge clk_i); #1;
            rk_valid_i = 1'b0;
            rnd_done_i = 1'b0;
            abort_i    = 1'b0;
            if (in_ready_o) busy = 1'b0;
            if (ks_load_o) begin
                chk("ks_key", ks_key_o, cur_key);
                kkey = ks_key_o; nstart = 0; exp_idx = 0; kdly = pick();
            end
            if (rk_req_o) begin
                if (kdly == 0) begin
                    chk("rk_idx", 128'(rk_idx_o), 128'(exp_idx));
                    rk_valid_i = 1'b1;
                    rk_data_i  = aes_rk(kkey, exp_idx);
                    exp_idx++;
                    kdly = pick();
                end else kdly--;
            end
            if (rnd_start_o) begin
                nstart++;
                chk("rnd_last", 128'(rnd_last_o), 128'(nstart == 10));
                if (nstart == 1) first_st = rnd_state_o;
                cap_st = rnd_state_o; cap_k = rnd_key_o; busy = 1'b1; rdly = pick();
            end
            if (busy && !hang) begin
                if (rdly == 0) begin
                    rnd_done_i   = 1'b1;
                    rnd_result_i = aes_round(cap_st, cap_k, nstart == 10);
                    busy = 1'b0;
                    if (abort_round != 0 && nstart == abort_round) begin
                        abort_i = 1'b1;
                        abort_round = 0;
                    end
                end else rdly--;
            end
        end
    end

    // ---------------- stimulus ----------------
    localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] S01 = 128'h00102030405060708090a0b0c0d0e0f0;

    task automatic start_op(input logic [127:0] pt, input logic [127:0] key);
        cur_key = key;
        @(posedge clk_i); #1;
        in_valid_i = 1'b1; in_data_i = pt; in_key_i = key;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
    endtask

    task automatic do_op(input logic [127:0] pt, input logic [127:0] key, input int hold,
                         output logic [127:0] ct);
        int n = 0;
        start_op(pt, key);
        @(negedge clk_i);
        while (!out_valid_o && n < 4000) begin @(negedge clk_i); n++; end
        if (!out_valid_o) begin
            chk("op_timeout", 128'd0, 128'd1);
            ct = '0;
            return;
        end
        ct = out_data_o;
        for (int i = 0; i < hold; i++) begin
            chk("hold_valid", 128'(out_valid_o), 128'd1);
            chk("hold_data", out_data_o, ct);
            chk("hold_inrdy", 128'(in_ready_o), 128'd0);
            @(negedge clk_i);
        end
        @(posedge clk_i); #1 out_ready_i = 1'b1;
        @(negedge clk_i);
        chk("rel_inrdy", 128'(in_ready_o), 128'd0);
        @(posedge clk_i); #1 out_ready_i = 1'b0;
        @(negedge clk_i);
        chk("idle_inrdy", 128'(in_ready_o), 128'd1);
        chk("idle_oval", 128'(out_valid_o), 128'd0);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_inrdy"}, 128'(in_ready_o), 128'd1);
        chk({tag, "_ctl"}, 128'({ks_load_o, rk_req_o, rnd_start_o, rnd_last_o, out_valid_o, err_o}), 128'd0);
        chk({tag, "_idx"}, 128'(rk_idx_o), 128'd0);
        chk({tag, "_kskey"}, ks_key_o, 128'd0);
        chk({tag, "_rstate"}, rnd_state_o, 128'd0);
        chk({tag, "_rkey"}, rnd_key_o, 128'd0);
        chk({tag, "_odata"}, out_data_o, 128'd0);
    endtask

    initial begin
        logic [127:0] ct, pt, key;
        int n, t0, t1;
        bit seen;
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
        end
        rst_i = 1'b1; in_valid_i = 1'b0; in_data_i = '0; in_key_i = '0; out_ready_i = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk_reset_outs("reset");
        rst_i = 1'b0;

        // FIPS-197 C.1, zero-wait peers
        zero_mode = 1'b1;
        do_op(PT1, K1, 0, ct);
        chk("c1_ct", ct, CT1);
        chk("c1_model", aes_enc(PT1, K1), CT1);
        chk("c1_rk0", first_st, S01);
        chk("c1_nstart", 128'(nstart), 128'd10);

        // random peer latency, random vectors
        zero_mode = 1'b0;
        do_op(PT1, K1, 0, ct);
        chk("rnd_c1_ct", ct, CT1);
        chk("rnd_nstart", 128'(nstart), 128'd10);
        for (int k = 0; k < 3; k++) begin
            pt  = {$urandom, $urandom, $urandom, $urandom};
            key = {$urandom, $urandom, $urandom, $urandom};
            do_op(pt, key, 0, ct);
            chk("rand_ct", ct, aes_enc(pt, key));
            chk("rand_rk0", first_st, pt ^ key);
        end

        // consumer back-pressure
        do_op(PT1, K1, 30, ct);
        chk("bp_ct", ct, CT1);

        // abort together with rnd_done of round 5
        abort_round = 5;
        start_op(PT1, K1);
        n = 0;
        @(negedge clk_i);
        while (!abort_i && n < 3000) begin @(negedge clk_i); n++; end
        chk("abort_seen", 128'(abort_i), 128'd1);
        chk("abort_rnddone", 128'(rnd_done_i), 128'd1);
        @(negedge clk_i);
        chk("abort_idle", 128'(in_ready_o), 128'd1);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            seen |= out_valid_o;
            @(negedge clk_i);
        end
        chk("abort_no_oval", 128'(seen), 128'd0);
        do_op(PT1, K1, 0, ct);
        chk("post_abort_ct", ct, CT1);

        // round unit hangs: watchdog
        hang = 1'b1;
        start_op(PT1, K1);
        n = 0; t0 = 0; t1 = 0;
        @(negedge clk_i);
        while (!rnd_start_o && n < 1000) begin @(negedge clk_i); n++; end
        chk("wd_start", 128'(rnd_start_o), 128'd1);
        t0 = cyc;
        n = 0;
        @(negedge clk_i);
        while (!err_o && n < 200) begin @(negedge clk_i); n++; end
        chk("wd_err", 128'(err_o), 128'd1);
        t1 = cyc;
        chk("wd_cycles", 128'(t1 - t0), 128'd64);
        @(negedge clk_i);
        chk("wd_err_pulse", 128'(err_o), 128'd0);
        chk("wd_idle", 128'(in_ready_o), 128'd1);
        hang = 1'b0;
        do_op(PT1, K1, 0, ct);
        chk("post_wd_ct", ct, CT1);

        // reset during FETCH of round 3
        start_op(PT1, K1);
        n = 0;
        @(negedge clk_i);
        while (!(rk_req_o && rk_idx_o == 4'd3) && n < 2000) begin @(negedge clk_i); n++; end
        chk("rst_fetch3", 128'(rk_req_o && rk_idx_o == 4'd3), 128'd1);
        rst_i = 1'b1;
        @(negedge clk_i);
        chk_reset_outs("midrst");
        rst_i = 1'b0;
        do_op(PT1, K1, 0, ct);
        chk("post_rst_ct", ct, CT1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
